regbank_port_arbiter: RTL

- Shares the single-write-port 16x8 register bank between two requesters, one access per clock, with round-robin fairness.
- Requester 0 is the calculator operation controller (STORE/LOAD). Requester 1 is the display/debug scan sequencer.
- Each requester gets a per-port read-return path with 1-cycle latency, a contention counter and an out-of-range address error pulse.

---
 rtl/regbank_port_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/regbank_port_arbiter.sv
// -----------------------------------------------------------------------------
// regbank_port_arbiter
//
// Lets two requesters share the single access port of the register bank,
// one access per clock, with round-robin priority on ties.
//   port 0 : calculator operation controller (STORE/LOAD)
//   port 1 : display/debug scan sequencer
//
// Ports
//   clk, reset                 system clock (rising edge), async active-high reset
//   rN_req/we/addr/wdata       requester N access request, held until granted
//   rN_gnt                     access performed for port N this cycle (comb)
//   rN_rvalid/rdata            registered read return, one cycle after grant
//   rf_we/addr/wdata           drive of the register bank port
//   rf_rdata                   combinational read data of the bank at rf_addr
//   err                        1-cycle pulse: last granted access was out of range
//   conflict_cnt               saturating count of cycles with both requests high
// -----------------------------------------------------------------------------
module regbank_port_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,

    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,

    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [DATA_W-1:0] rf_rdata,

    output logic              err,
    output logic [7:0]        conflict_cnt
);

    // One extra bit so DEPTH == 2^ADDR_W is representable.
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);
    localparam logic [7:0]      CNT_MAX   = 8'hFF;

    // Registered state
    logic              last_gnt_q,     last_gnt_d;     // 1: port 1 won last
    logic              r0_rvalid_q,    r0_rvalid_d;
    logic [DATA_W-1:0] r0_rdata_q,     r0_rdata_d;
    logic              r1_rvalid_q,    r1_rvalid_d;
    logic [DATA_W-1:0] r1_rdata_q,     r1_rdata_d;
    logic              err_q,          err_d;
    logic [7:0]        conflict_cnt_q, conflict_cnt_d;

    // Combinational access selection
    logic              gnt0;
    logic              gnt1;
    logic              any_gnt;
    logic              both_req;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              in_range;

    // -------------------------------------------------------------------------
    // Arbitration and bank drive
    // -------------------------------------------------------------------------
    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        both_req  = r0_req & r1_req;

        // Holding reset kills grants combinationally so a write in flight at
        // the moment reset rises never reaches the bank.
        if (!reset) begin
            // Port 0 wins a tie only when port 1 had the previous grant.
            if (r0_req && (!r1_req || last_gnt_q)) begin
                gnt0 = 1'b1;
            end else if (r1_req) begin
                gnt1 = 1'b1;
            end
        end

        if (gnt0) begin
            sel_we    = r0_we;
            sel_addr  = r0_addr;
            sel_wdata = r0_wdata;
        end else if (gnt1) begin
            sel_we    = r1_we;
            sel_addr  = r1_addr;
            sel_wdata = r1_wdata;
        end

        any_gnt  = gnt0 | gnt1;
        in_range = ({1'b0, sel_addr} < DEPTH_LIM);
    end

    assign r0_gnt   = gnt0;
    assign r1_gnt   = gnt1;
    assign rf_we    = any_gnt & sel_we & in_range;
    assign rf_addr  = sel_addr;
    assign rf_wdata = sel_wdata;

    // -------------------------------------------------------------------------
    // Next-state: read return, error pulse, priority and contention count
    // -------------------------------------------------------------------------
    always_comb begin
        last_gnt_d     = last_gnt_q;
        r0_rvalid_d    = 1'b0;
        r0_rdata_d     = r0_rdata_q;
        r1_rvalid_d    = 1'b0;
        r1_rdata_d     = r1_rdata_q;
        err_d          = 1'b0;
        conflict_cnt_d = conflict_cnt_q;

        if (gnt0) begin
            last_gnt_d = 1'b0;
        end else if (gnt1) begin
            last_gnt_d = 1'b1;
        end

        // Out-of-range accesses consume the grant but return nothing.
        if (any_gnt && !in_range) begin
            err_d = 1'b1;
        end

        if (gnt0 && !sel_we && in_range) begin
            r0_rvalid_d = 1'b1;
            r0_rdata_d  = rf_rdata;
        end

        if (gnt1 && !sel_we && in_range) begin
            r1_rvalid_d = 1'b1;
            r1_rdata_d  = rf_rdata;
        end

        if (both_req && (conflict_cnt_q != CNT_MAX)) begin
            conflict_cnt_d = conflict_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_gnt_q     <= 1'b1;
            r0_rvalid_q    <= 1'b0;
            r0_rdata_q     <= '0;
            r1_rvalid_q    <= 1'b0;
            r1_rdata_q     <= '0;
            err_q          <= 1'b0;
            conflict_cnt_q <= '0;
        end else begin
            last_gnt_q     <= last_gnt_d;
            r0_rvalid_q    <= r0_rvalid_d;
            r0_rdata_q     <= r0_rdata_d;
            r1_rvalid_q    <= r1_rvalid_d;
            r1_rdata_q     <= r1_rdata_d;
            err_q          <= err_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign r0_rvalid    = r0_rvalid_q;
    assign r0_rdata     = r0_rdata_q;
    assign r1_rvalid    = r1_rvalid_q;
    assign r1_rdata     = r1_rdata_q;
    assign err          = err_q;
    assign conflict_cnt = conflict_cnt_q;

endmodule
